hk_spi_responder: RTL and testbench

SPI mode-0 responder for the housekeeping register bank, serving external SPI hosts on mgmt_io_in[4:2] (SCK, CSB, SDI) and mgmt_io_out[1] (SDO). All SPI pins are oversampled on the system clock. Host transactions are decoded into single-cycle register read and write strobes with an auto-incrementing byte address. Register bank sits behind reg_* ports; block instantiated inside mgmt_soc_hk.

---
 rtl/hk_spi_responder.sv | 205 ++++++++++++++++++++
 tb/tb_hk_spi_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hk_spi_responder.sv
`timescale 1ns/1ps
// hk_spi_responder: oversampled SPI mode-0 responder that turns host
// transactions into single-cycle register read/write strobes with an
// auto-incrementing byte address.
module hk_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sck,
  input  logic              csb,
  input  logic              sdi,
  output logic              sdo,
  output logic              sdo_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SS-1:0]     r_sck_sync;
  logic [SS-1:0]     r_csb_sync;
  logic [SS-1:0]     r_sdi_sync;
  logic [SS-1:0]     r_vld;
  logic              r_sck_d;
  logic              r_armed;
  logic [2:0]        r_bit_cnt;
  logic [2:0]        r_byte_cnt;
  logic [2:0]        r_n;
  logic [6:0]        r_rx;
  logic [7:0]        r_tx;
  logic [7:0]        r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic              r_rd;
  logic              r_more;
  logic              r_p1;
  logic              r_p2;
  logic              r_we;
  logic              r_re;
  logic              r_oe;
  logic              r_busy;

  logic              w_sck;
  logic              w_csb;
  logic              w_sdi;
  logic              w_rise;
  logic              w_fall;
  logic              w_active;
  logic              w_byte_done;
  logic [7:0]        w_byte;
  logic [2:0]        w_cnt_inc;

  assign w_sck       = r_sck_sync[SS-1];
  assign w_csb       = r_csb_sync[SS-1];
  assign w_sdi       = r_sdi_sync[SS-1];
  assign w_rise      = w_sck & ~r_sck_d;
  assign w_fall      = ~w_sck & r_sck_d;
  assign w_active    = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_byte_done = w_rise & w_active & ~w_csb & (r_bit_cnt == 3'd7);
  assign w_byte      = {r_rx, w_sdi};
  assign w_cnt_inc   = r_byte_cnt + 3'd1;

  assign sdo       = r_tx[7];
  assign sdo_oe    = r_oe;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign reg_re    = r_re;
  assign busy      = r_busy;

  // Input synchronizers; r_vld marks when the csb chain holds a real sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_sync <= '0;
      r_csb_sync <= '1;
      r_sdi_sync <= '0;
      r_vld      <= '0;
    end else begin
      r_sck_sync <= {r_sck_sync[SS-2:0], sck};
      r_csb_sync <= {r_csb_sync[SS-2:0], csb};
      r_sdi_sync <= {r_sdi_sync[SS-2:0], sdi};
      r_vld      <= {r_vld[SS-2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; csb high returns to IDLE from anywhere.
  always_comb begin
    w_state_nxt = r_state;
    if (w_csb) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (r_armed) w_state_nxt = S_CMD;
        S_CMD:  if (w_byte_done) w_state_nxt = (w_byte[7:6] == 2'b00) ? S_DONE : S_ADDR;
        S_ADDR: if (w_byte_done) w_state_nxt = S_DATA;
        S_DATA: if (w_byte_done && (r_n != 3'd0) && (w_cnt_inc == r_n)) w_state_nxt = S_DONE;
        S_DONE: w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Shift registers, strobe pipeline (R+1 we/re, R+2 addr++, R+3 re, R+4 tx).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck_d    <= 1'b0;
      r_armed    <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_byte_cnt <= 3'd0;
      r_n        <= 3'd0;
      r_rx       <= 7'd0;
      r_tx       <= 8'd0;
      r_wdata    <= 8'd0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_more     <= 1'b0;
      r_p1       <= 1'b0;
      r_p2       <= 1'b0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sck_d <= w_sck;
      r_busy  <= ~w_csb;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_p1    <= 1'b0;
      r_p2    <= r_p1;

      // Arm only once csb has been seen high after reset.
      if (r_vld[SS-1] && w_csb) r_armed <= 1'b1;

      if (w_csb) begin
        r_bit_cnt  <= 3'd0;
        r_byte_cnt <= 3'd0;
      end else if (w_rise && w_active) begin
        r_rx      <= w_byte[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_byte_done) begin
        case (r_state)
          S_CMD: begin
            r_wr <= w_byte[7];
            r_rd <= w_byte[6];
            r_n  <= w_byte[5:3];
          end
          S_ADDR: begin
            r_addr <= ADDR_W'(w_byte);
            r_re   <= r_rd;
          end
          S_DATA: begin
            r_we       <= r_wr;
            if (r_wr) r_wdata <= w_byte;
            r_p1       <= 1'b1;
            r_more     <= (r_n == 3'd0) || (w_cnt_inc != r_n);
            r_byte_cnt <= w_cnt_inc;
          end
          default: ;
        endcase
      end

      if (r_p1) r_addr <= r_addr + ADDR_W'(1);
      if (r_p2 && r_rd && r_more && (r_state == S_DATA) && !w_csb) r_re <= 1'b1;

      // Falls inside a byte shift; the fall after bit 8 keeps the fresh byte.
      if (w_fall && (r_state == S_DATA) && r_rd && !w_csb && (r_bit_cnt != 3'd0)) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
      if (r_re) begin
        r_tx <= reg_rdata;
        r_oe <= 1'b1;
      end
      if (w_csb || (r_state == S_IDLE) || (r_state == S_DONE)) r_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hk_spi_responder.sv
`timescale 1ns/1ps
// tb_hk_spi_responder: table-driven SPI host transactions against a small
// register-bank model, plus abort and mid-transaction reset sequences.
module tb_hk_spi_responder;

  logic       clk;
  logic       resetn;
  logic       sck;
  logic       csb;
  logic       sdi;
  logic       sdo;
  logic       sdo_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  hk_spi_responder #(.SYNC_STAGES(2), .ADDR_W(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sck       (sck),
    .csb       (csb),
    .sdi       (sdi),
    .sdo       (sdo),
    .sdo_oe    (sdo_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0]      cmd;
    logic [7:0]      addr;
    logic [2:0]      nb;
    logic [3:0][7:0] mosi;
    logic [3:0][7:0] miso;
    logic [3:0]      miso_chk;
    logic [2:0]      n_we;
    logic [2:0]      n_re;
    logic            oe_seen;
    logic            oe_end;
  } vec_t;

  int         n_vec;
  int         n_bad;
  logic       do_init;
  logic [7:0] mem [256];
  logic [7:0] we_a [$];
  logic [7:0] we_d [$];
  logic [7:0] re_a [$];
  int         both_cnt;
  int         dbl_cnt;
  logic       oe_seen;
  logic       prev_we;
  logic       prev_re;
  vec_t       vt [7];

  assign reg_rdata = mem[reg_addr];

  function automatic logic [7:0] img(input int i);
    case (i)
      8'h00:   return 8'h77;
      8'h01:   return 8'h04;
      8'h02:   return 8'h56;
      8'h20:   return 8'h3C;
      8'hFF:   return 8'h99;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  function automatic logic [3:0][7:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  // Register-bank model and strobe logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 256; i++) mem[i] = img(i);
      we_a.delete();
      we_d.delete();
      re_a.delete();
      both_cnt = 0;
      dbl_cnt  = 0;
      oe_seen  = 1'b0;
    end else begin
      if (reg_we) begin
        we_a.push_back(reg_addr);
        we_d.push_back(reg_wdata);
        mem[reg_addr] = reg_wdata;
      end
      if (reg_re) re_a.push_back(reg_addr);
      if (reg_we && reg_re) both_cnt++;
      if ((reg_we && prev_we) || (reg_re && prev_re)) dbl_cnt++;
      if (sdo_oe) oe_seen = 1'b1;
    end
    prev_we = reg_we;
    prev_re = reg_re;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " sdo"},       32'(sdo),       32'd0);
    chk({tag, " sdo_oe"},    32'(sdo_oe),    32'd0);
    chk({tag, " reg_addr"},  32'(reg_addr),  32'd0);
    chk({tag, " reg_wdata"}, 32'(reg_wdata), 32'd0);
    chk({tag, " reg_we"},    32'(reg_we),    32'd0);
    chk({tag, " reg_re"},    32'(reg_re),    32'd0);
    chk({tag, " busy"},      32'(busy),      32'd0);
  endtask

  // Mode 0 host: data set while sck low, both sides sample on the rise.
  task automatic spi_bits(input logic [7:0] mo, input int nb, output logic [7:0] mi);
    mi = 8'd0;
    for (int i = 0; i < nb; i++) begin
      sdi = mo[7-i];
      #100;
      sck = 1'b1;
      mi  = {mi[6:0], sdo};
      #100;
      sck = 1'b0;
    end
  endtask

  task automatic reinit();
    do_init = 1'b1;
    repeat (2) @(negedge clk);
    do_init = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] mi;
    logic [7:0] got [4];
    logic       oe_end;
    reinit();
    csb = 1'b0;
    #100;
    chk($sformatf("v%0d busy_on", idx), 32'(busy), 32'd1);
    spi_bits(v.cmd, 8, mi);
    spi_bits(v.addr, 8, mi);
    for (int k = 0; k < int'(v.nb); k++) begin
      spi_bits(v.mosi[k], 8, mi);
      got[k] = mi;
    end
    #100;
    oe_end = sdo_oe;
    csb = 1'b1;
    #400;
    for (int k = 0; k < int'(v.nb); k++)
      if (v.miso_chk[k]) chk($sformatf("v%0d miso%0d", idx, k), 32'(got[k]), 32'(v.miso[k]));
    chk($sformatf("v%0d n_we", idx), 32'(we_a.size()), 32'(v.n_we));
    for (int k = 0; k < we_a.size() && k < int'(v.n_we); k++) begin
      chk($sformatf("v%0d we_addr%0d", idx, k), 32'(we_a[k]), 32'(8'(v.addr + 8'(k))));
      chk($sformatf("v%0d we_data%0d", idx, k), 32'(we_d[k]), 32'(v.mosi[k]));
    end
    chk($sformatf("v%0d n_re", idx), 32'(re_a.size()), 32'(v.n_re));
    for (int k = 0; k < re_a.size() && k < int'(v.n_re); k++)
      chk($sformatf("v%0d re_addr%0d", idx, k), 32'(re_a[k]), 32'(8'(v.addr + 8'(k))));
    chk($sformatf("v%0d oe_seen", idx), 32'(oe_seen), 32'(v.oe_seen));
    chk($sformatf("v%0d oe_end", idx),  32'(oe_end),  32'(v.oe_end));
    chk($sformatf("v%0d we_re_overlap", idx), 32'(both_cnt), 32'd0);
    chk($sformatf("v%0d strobe_width", idx),  32'(dbl_cnt),  32'd0);
    chk($sformatf("v%0d busy_off", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    logic [7:0] mi;
    n_vec   = 0;
    n_bad   = 0;
    do_init = 1'b1;
    resetn  = 1'b0;
    csb     = 1'b1;
    sck     = 1'b0;
    sdi     = 1'b0;

    //                cmd    addr   nb    mosi                          miso                          chk      we    re    seen  end
    vt[0] = '{8'h40, 8'h01, 3'd2, pk(8'h00,8'h00,8'h00,8'h00), pk(8'h04,8'h56,8'h00,8'h00), 4'b0011, 3'd0, 3'd3, 1'b1, 1'b1};
    vt[1] = '{8'h80, 8'h10, 3'd2, pk(8'hA5,8'h5A,8'h00,8'h00), pk(8'h00,8'h00,8'h00,8'h00), 4'b0000, 3'd2, 3'd0, 1'b0, 1'b0};
    vt[2] = '{8'h48, 8'h20, 3'd2, pk(8'h00,8'h00,8'h00,8'h00), pk(8'h3C,8'h00,8'h00,8'h00), 4'b0001, 3'd0, 3'd1, 1'b1, 1'b0};
    vt[3] = '{8'hC0, 8'hFF, 3'd2, pk(8'h11,8'h22,8'h00,8'h00), pk(8'h99,8'h77,8'h00,8'h00), 4'b0011, 3'd2, 3'd3, 1'b1, 1'b1};
    vt[4] = '{8'h88, 8'h30, 3'd2, pk(8'h12,8'h34,8'h00,8'h00), pk(8'h00,8'h00,8'h00,8'h00), 4'b0000, 3'd1, 3'd0, 1'b0, 1'b0};
    vt[5] = '{8'h3F, 8'h01, 3'd2, pk(8'hAB,8'hCD,8'h00,8'h00), pk(8'h00,8'h00,8'h00,8'h00), 4'b0000, 3'd0, 3'd0, 1'b0, 1'b0};
    vt[6] = '{8'hD0, 8'h7E, 3'd3, pk(8'hE1,8'hE2,8'hE3,8'h00), pk(8'h75,8'h7C,8'h00,8'h00), 4'b0011, 3'd2, 3'd2, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk_rst("por");
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    do_init = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Abort mid data byte: partial byte must not write.
    reinit();
    csb = 1'b0;
    #100;
    spi_bits(8'h80, 8, mi);
    spi_bits(8'h05, 8, mi);
    spi_bits(8'hF0, 4, mi);
    #100;
    csb = 1'b1;
    #400;
    chk("abort n_we", 32'(we_a.size()), 32'd0);
    chk("abort n_re", 32'(re_a.size()), 32'd0);
    chk("abort oe_seen", 32'(oe_seen), 32'd0);
    run_vec(vt[0], 10);

    // Reset during the address byte; host keeps clocking with csb low.
    reinit();
    csb = 1'b0;
    #100;
    spi_bits(8'h80, 8, mi);
    spi_bits(8'h40, 4, mi);
    resetn = 1'b0;
    #1;
    chk_rst("midrst");
    #99;
    resetn = 1'b1;
    spi_bits(8'h04, 4, mi);
    spi_bits(8'h77, 8, mi);
    #100;
    chk("midrst n_we", 32'(we_a.size()), 32'd0);
    chk("midrst n_re", 32'(re_a.size()), 32'd0);
    chk("midrst oe_seen", 32'(oe_seen), 32'd0);
    csb = 1'b1;
    #400;
    run_vec(vt[3], 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
